spi_target_core: RTL and testbench
==================================

# spi_target_core

SPI target (slave) engine: the far end of the SPI controller link, answering an external controller on the nss/sck/mosi/miso pins. All pins are synchronised into `clk_i` and edges are detected by oversampling. Received words are pushed into an RX FIFO, and transmit words are taken from a first-word-fall-through TX FIFO. It sits beside the APB4 register block, which supplies configuration and instantiates both FIFOs.

## Interface

**Parameters**
- None. The data path is fixed at 32 bits.

**Ports**
- `clk_i` in 1 — system clock.
- `rst_n_i` in 1 — asynchronous, active-low reset.
- `en_i` in 1 — core enable. Low forces IDLE.
- `cpol_i` in 1 — sck idle level.
- `cpha_i` in 1 — 0: sample on leading edge; 1: sample on trailing edge.
- `lsb_i` in 1 — 1: LSB first.
- `dsize_i` in 2 — word size: 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
- `tx_valid_i` in 1 — TX FIFO not empty.
- `tx_data_i` in 32 — TX FIFO head word, right-aligned.
- `tx_ready_o` out 1 — single-cycle pop pulse.
- `rx_valid_o` out 1 — single-cycle push pulse.
- `rx_ready_i` in 1 — RX FIFO not full.
- `rx_data_o` out 32 — received word, right-aligned, zero-extended.
- `spi_sck_i` in 1 — serial clock from the controller.
- `spi_nss_i` in 1 — chip select, active low.
- `spi_mosi_i` in 1 — serial data in.
- `spi_miso_o` out 1 — serial data out.
- `spi_miso_en_o` out 1 — miso output-enable.
- `busy_o` out 1 — state is ACTIVE.
- `tx_udf_o` out 1 — pulse: a word was sent with no TX data available.
- `rx_ovf_o` out 1 — pulse: a received word was dropped because the RX FIFO was full.
- `frm_err_o` out 1 — pulse: nss deasserted mid-word.

## Operation

**Synchroniser and edge detection**
- Two-flop synchronisers on sck, nss and mosi.
- A third register on sck and nss provides edge detection.
- Reset values: sck sync = 0, nss sync = 1, mosi sync = 0.
- Leading edge = sck transition away from the `cpol` level. Trailing edge = the opposite transition.
- Sample edge = leading edge if cpha = 0, else trailing edge. Drive edge = the other edge.

**Configuration latch**
- cpol, cpha, lsb and dsize are latched at frame start.
- Changes to these inputs during ACTIVE are ignored until the next frame.
- N denotes the latched word size in bits.

**FSM**
- IDLE -> ACTIVE on a synchronised nss falling edge while `en_i` = 1.
- ACTIVE -> IDLE on an nss rising edge, or when `en_i` = 0, on the same cycle.
- In IDLE, sck edges are ignored.

**Drive events**
- A drive event is the frame-start cycle (cpha = 0 only) or any drive edge.
- On a drive event with tx_cnt = 0, the TX shift register loads:
  - `tx_data_i` if `tx_valid_i` = 1 (this is a peek; nothing is popped yet), setting tx_have = 1;
  - otherwise zero, setting tx_have = 0.
- MSB-first loads are left-aligned (word << (32 − N)) and miso = bit 31.
- LSB-first loads use miso = bit 0.
- On any other drive event, the register shifts by one toward the output bit.
- tx_cnt increments modulo N on every drive event.

**Sample edges**
- mosi shifts into rx_sr:
  - MSB-first: {rx_sr[30:0], mosi};
  - LSB-first: {mosi, rx_sr[31:1]}.
- rx_cnt increments.
- On the sample of bit 0 of a word:
  - if tx_have = 1, pulse `tx_ready_o` (the pop happens only once the word is committed);
  - else pulse `tx_udf_o`.
- When rx_cnt reaches N:
  - capture `rx_data_o` (MSB-first: low N bits; LSB-first: rx_sr >> (32 − N));
  - clear rx_cnt;
  - if `rx_ready_i` = 1, pulse `rx_valid_o`, else pulse `rx_ovf_o` (the word is dropped).

**Frame end**
- Pulse `frm_err_o` if rx_cnt ≠ 0.
- Discard any partial word and clear both counters.
- A TX word that was peeked but not yet sampled is not popped.

**Output enable**
- `spi_miso_en_o` = 1 only in ACTIVE.
- `spi_miso_o` = 0 in IDLE.

## Timing

**Reset values**
- All outputs 0; `rx_data_o` = 0; state IDLE.

**Latency and timing constraints**
- Pin-to-action latency is 3 `clk_i` cycles.
- sck high and low phases must each be ≥ 4 `clk_i` cycles.
- nss-fall to first sck edge must be ≥ 6 cycles.
- miso is valid 4 cycles after nss-fall (cpha = 0) or 4 cycles after a drive edge.

**Pulse timing**
- `rx_valid_o` is asserted the cycle after the last sample edge and stays high for exactly 1 cycle.
- `rx_data_o` holds until the next capture.
- `tx_ready_o` is 1 cycle wide, in the cycle after bit 0's sample edge.

**Boundary conditions**
- Back-to-back words within one nss-low period are supported with no gap.
- If nss rises on the same cycle as a sample edge, frame end wins and the edge is ignored.
- Asynchronous reset mid-frame returns the block to IDLE immediately; the next frame requires a fresh nss-fall.

## Test plan

1. **Basic 8-bit exchange.** cpol = 0, cpha = 0, MSB-first, dsize = 0, tx head 0xA5; controller sends 0x3C.
   -> miso carries 1,0,1,0,0,1,0,1; one `tx_ready_o` pulse; `rx_data_o` = 0x0000003C with a single `rx_valid_o`.
2. **All four modes, LSB-first.** Each cpol/cpha combination, dsize = 1, tx 0x1234, mosi word 0xBEEF.
   -> `rx_data_o` = 0x0000BEEF; the controller captures 0x1234 in every mode.
3. **Back-to-back 32-bit words.** Two words in one nss-low period, tx FIFO holds 0xDEADBEEF and 0x01234567.
   -> two `rx_valid_o` pulses, two pops; miso matches both words in order.
4. **Underflow.** Empty TX FIFO, 8-bit frame.
   -> miso all 0; `tx_udf_o` pulses once; `tx_ready_o` never asserts.
5. **Overflow.** `rx_ready_i` = 0 at word end.
   -> `rx_ovf_o` pulses; `rx_valid_o` stays 0.
6. **Abort mid-word.** nss rises after 5 of 8 bits.
   -> `frm_err_o` pulses, no push. The next frame receives 0x81 correctly, with a pop only if bit 0 had already been sampled. Repeat with `rst_n_i` low mid-frame -> all outputs 0 and `busy_o` = 0.

Source files
------------

// File: rtl/spi_target_core.sv
// SPI target engine: oversamples nss/sck/mosi into clk_i, shifts 8/16/24/32-bit
// words in and out in any cpol/cpha mode, and exchanges words with the RX FIFO
// (push) and a first-word-fall-through TX FIFO (peek, then pop once committed).
module spi_target_core (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic        lsb_i,
    input  logic [1:0]  dsize_i,
    input  logic        tx_valid_i,
    input  logic [31:0] tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [31:0] rx_data_o,
    input  logic        spi_sck_i,
    input  logic        spi_nss_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_en_o,
    output logic        busy_o,
    output logic        tx_udf_o,
    output logic        rx_ovf_o,
    output logic        frm_err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Synchroniser chains; index 0 is the first stage, index 2 the edge-detect copy.
    logic [2:0] sck_sync;
    logic [2:0] nss_sync;
    logic [1:0] mosi_sync;

    logic sck_rise, sck_fall, nss_fall, nss_rise, mosi_s;

    // Configuration latched at frame start.
    logic       cfg_cpol;
    logic       cfg_cpha;
    logic       cfg_lsb;
    logic [1:0] cfg_dsize;

    // Shift engine state.
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [4:0]  tx_cnt;
    logic [4:0]  rx_cnt;
    logic        tx_have;

    // Decoded events.
    logic        frame_start, frame_end;
    logic        lead_edge, trail_edge;
    logic        sample_edge, drive_edge;
    logic [4:0]  last_idx;
    logic [4:0]  shamt;
    logic [31:0] rx_next;
    logic [31:0] rx_word;

    // Left-align an MSB-first word so its top bit sits at bit 31; LSB-first words stay put.
    function automatic logic [31:0] tx_align(input logic [31:0] word,
                                             input logic        lsb,
                                             input logic [1:0]  dsz);
        logic [4:0] sh;
        sh = {~dsz, 3'b000};
        return lsb ? word : (word << sh);
    endfunction

    // Pin synchronisers and edge-detect registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_sync  <= 3'b000;
            nss_sync  <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck_i};
            nss_sync  <= {nss_sync[1:0], spi_nss_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign nss_fall = ~nss_sync[1] & nss_sync[2];
    assign nss_rise = nss_sync[1] & ~nss_sync[2];
    assign mosi_s   = mosi_sync[1];

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and frame start/end strobes.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && nss_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (nss_rise || !en_i) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Classify sck edges with the latched mode; a frame end on the same cycle suppresses them.
    always_comb begin
        lead_edge   = cfg_cpol ? sck_fall : sck_rise;
        trail_edge  = cfg_cpol ? sck_rise : sck_fall;
        sample_edge = 1'b0;
        drive_edge  = 1'b0;
        if (state_q == ACTIVE && !frame_end) begin
            sample_edge = cfg_cpha ? trail_edge : lead_edge;
            drive_edge  = cfg_cpha ? lead_edge  : trail_edge;
        end
    end

    // Word-size helpers and the post-shift receive word.
    always_comb begin
        last_idx = {cfg_dsize, 3'b111};
        shamt    = {~cfg_dsize, 3'b000};
        rx_next  = cfg_lsb ? {mosi_s, rx_sr[31:1]} : {rx_sr[30:0], mosi_s};
        rx_word  = cfg_lsb ? (rx_next >> shamt) : (rx_next & ({32{1'b1}} >> shamt));
    end

    // Shift engine: config latch, TX load/shift, RX sampling, FIFO handshakes and status pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_cpol   <= 1'b0;
            cfg_cpha   <= 1'b0;
            cfg_lsb    <= 1'b0;
            cfg_dsize  <= 2'd0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            tx_have    <= 1'b0;
            rx_data_o  <= '0;
            tx_ready_o <= 1'b0;
            rx_valid_o <= 1'b0;
            tx_udf_o   <= 1'b0;
            rx_ovf_o   <= 1'b0;
            frm_err_o  <= 1'b0;
        end else begin
            tx_ready_o <= 1'b0;
            rx_valid_o <= 1'b0;
            tx_udf_o   <= 1'b0;
            rx_ovf_o   <= 1'b0;
            frm_err_o  <= 1'b0;

            if (frame_start) begin
                cfg_cpol  <= cpol_i;
                cfg_cpha  <= cpha_i;
                cfg_lsb   <= lsb_i;
                cfg_dsize <= dsize_i;
                rx_sr     <= '0;
                rx_cnt    <= '0;
                // cpha=0 drives bit 0 straight away, so the first load uses the live config.
                if (!cpha_i) begin
                    tx_sr   <= tx_align(tx_valid_i ? tx_data_i : '0, lsb_i, dsize_i);
                    tx_have <= tx_valid_i;
                    tx_cnt  <= 5'd1;
                end else begin
                    tx_have <= 1'b0;
                    tx_cnt  <= '0;
                end
            end else if (frame_end) begin
                frm_err_o <= (rx_cnt != '0);
                tx_cnt    <= '0;
                rx_cnt    <= '0;
                tx_have   <= 1'b0;
            end else begin
                if (drive_edge) begin
                    if (tx_cnt == '0) begin
                        tx_sr   <= tx_align(tx_valid_i ? tx_data_i : '0, cfg_lsb, cfg_dsize);
                        tx_have <= tx_valid_i;
                    end else begin
                        tx_sr <= cfg_lsb ? (tx_sr >> 1) : (tx_sr << 1);
                    end
                    tx_cnt <= (tx_cnt == last_idx) ? '0 : tx_cnt + 5'd1;
                end

                if (sample_edge) begin
                    rx_sr <= rx_next;
                    // The peeked TX word is popped only once its first bit has been exchanged.
                    if (rx_cnt == '0) begin
                        tx_ready_o <= tx_have;
                        tx_udf_o   <= ~tx_have;
                    end
                    if (rx_cnt == last_idx) begin
                        rx_data_o  <= rx_word;
                        rx_cnt     <= '0;
                        rx_valid_o <= rx_ready_i;
                        rx_ovf_o   <= ~rx_ready_i;
                    end else begin
                        rx_cnt <= rx_cnt + 5'd1;
                    end
                end
            end
        end
    end

    assign busy_o        = (state_q == ACTIVE);
    assign spi_miso_en_o = (state_q == ACTIVE);
    assign spi_miso_o    = (state_q == ACTIVE) & (cfg_lsb ? tx_sr[0] : tx_sr[31]);

endmodule

// File: tb/tb_spi_target_core.sv
// Directed bench for spi_target_core: a behavioural SPI controller drives the pins,
// a tiny TX FIFO model feeds the core, and each scenario checks its own results.
module tb_spi_target_core;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic        cpol_i, cpha_i, lsb_i;
    logic [1:0]  dsize_i;
    logic        tx_valid_i;
    logic [31:0] tx_data_i;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [31:0] rx_data_o;
    logic        spi_sck_i, spi_nss_i, spi_mosi_i;
    logic        spi_miso_o, spi_miso_en_o, busy_o;
    logic        tx_udf_o, rx_ovf_o, frm_err_o;

    int nchk  = 0;
    int nfail = 0;

    spi_target_core dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .en_i          (en_i),
        .cpol_i        (cpol_i),
        .cpha_i        (cpha_i),
        .lsb_i         (lsb_i),
        .dsize_i       (dsize_i),
        .tx_valid_i    (tx_valid_i),
        .tx_data_i     (tx_data_i),
        .tx_ready_o    (tx_ready_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .rx_data_o     (rx_data_o),
        .spi_sck_i     (spi_sck_i),
        .spi_nss_i     (spi_nss_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_en_o (spi_miso_en_o),
        .busy_o        (busy_o),
        .tx_udf_o      (tx_udf_o),
        .rx_ovf_o      (rx_ovf_o),
        .frm_err_o     (frm_err_o)
    );

    always #5 clk_i = ~clk_i;

    // TX FIFO model: first-word-fall-through, popped by tx_ready_o.
    logic [31:0] txq [4];
    int tx_len    = 0;
    int pop_start = 0;
    int pop_total = 0;
    int tx_idx;
    assign tx_idx     = pop_total - pop_start;
    assign tx_valid_i = (tx_idx < tx_len);
    assign tx_data_i  = txq[tx_idx & 3];

    always @(posedge clk_i) begin
        if (tx_ready_o) pop_total <= pop_total + 1;
    end

    // Pulse monitors (count high cycles) and a log of pushed words.
    int n_rxv = 0, n_txr = 0, n_udf = 0, n_ovf = 0, n_ferr = 0;
    logic [31:0] rx_log [8];
    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            rx_log[n_rxv & 7] <= rx_data_o;
            n_rxv <= n_rxv + 1;
        end
        if (tx_ready_o) n_txr  <= n_txr + 1;
        if (tx_udf_o)   n_udf  <= n_udf + 1;
        if (rx_ovf_o)   n_ovf  <= n_ovf + 1;
        if (frm_err_o)  n_ferr <= n_ferr + 1;
    end

    int b_rxv, b_txr, b_udf, b_ovf, b_ferr;

    task automatic snap();
        b_rxv  = n_rxv;
        b_txr  = n_txr;
        b_udf  = n_udf;
        b_ovf  = n_ovf;
        b_ferr = n_ferr;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load_tx(input int n, input logic [31:0] w0, input logic [31:0] w1);
        pop_start = pop_total;
        txq[0]    = w0;
        txq[1]    = w1;
        tx_len    = n;
    endtask

    // Controller side: mo[] words go out on mosi, mi[] collects miso.
    logic [31:0] mo [2];
    logic [31:0] mi [2];

    // abort_bits < 0 runs the full frame; otherwise nss rises after that many bits.
    // extra_lead adds one leading sck edge before nss rises; scramble changes the
    // config inputs while the frame is in progress.
    task automatic spi_frame(input logic cp, input logic ph, input logic lsb,
                             input logic [1:0] dsz, input int nwords,
                             input int abort_bits, input bit extra_lead,
                             input bit scramble);
        int n, total, w, idx, w2, idx2;
        n = (int'(dsz) + 1) * 8;
        total = (abort_bits >= 0) ? abort_bits : nwords * n;
        cpol_i = cp; cpha_i = ph; lsb_i = lsb; dsize_i = dsz;
        spi_sck_i = cp;
        mi[0] = '0; mi[1] = '0;
        wait_clks(6);
        spi_nss_i = 1'b0;
        if (!ph && total > 0) spi_mosi_i = mo[0][lsb ? 0 : n - 1];
        wait_clks(8);
        if (scramble) begin
            dsize_i = ~dsz;
            lsb_i   = ~lsb;
        end
        for (int k = 0; k < total; k++) begin
            w   = k / n;
            idx = lsb ? (k % n) : (n - 1 - (k % n));
            if (!ph) begin
                mi[w][idx] = spi_miso_o;
                spi_sck_i = ~cp;
                wait_clks(5);
                spi_sck_i = cp;
                if (k + 1 < total) begin
                    w2   = (k + 1) / n;
                    idx2 = lsb ? ((k + 1) % n) : (n - 1 - ((k + 1) % n));
                    spi_mosi_i = mo[w2][idx2];
                end
                wait_clks(5);
            end else begin
                spi_sck_i  = ~cp;
                spi_mosi_i = mo[w][idx];
                wait_clks(5);
                mi[w][idx] = spi_miso_o;
                spi_sck_i = cp;
                wait_clks(5);
            end
        end
        if (extra_lead) begin
            spi_sck_i = ~cp;
            wait_clks(5);
        end
        wait_clks(2);
        spi_nss_i = 1'b1;
        wait_clks(8);
        spi_sck_i = cp;
        wait_clks(6);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        wait_clks(3);
        nchk++;
        if ({spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o, tx_udf_o, rx_ovf_o, frm_err_o} !== 8'h00) begin
            nfail++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o, tx_udf_o, rx_ovf_o, frm_err_o});
        end
        nchk++;
        if (rx_data_o !== 32'h0) begin
            nfail++;
            $display("FAIL reset_rx_data: got %h required 00000000", rx_data_o);
        end
        rst_n_i = 1'b1;
        wait_clks(5);
        nchk++;
        if (busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL post_reset_busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_basic();
        load_tx(1, 32'hA5, 32'h0);
        mo[0] = 32'h3C;
        snap();
        spi_frame(1'b0, 1'b0, 1'b0, 2'd0, 1, -1, 1'b0, 1'b0);
        nchk++;
        if (mi[0] !== 32'hA5) begin
            nfail++;
            $display("FAIL basic_miso: got %h required 000000a5", mi[0]);
        end
        nchk++;
        if (rx_data_o !== 32'h3C) begin
            nfail++;
            $display("FAIL basic_rx_data: got %h required 0000003c", rx_data_o);
        end
        nchk++;
        if (n_rxv - b_rxv !== 1) begin
            nfail++;
            $display("FAIL basic_rx_valid_cycles: got %0d required 1", n_rxv - b_rxv);
        end
        nchk++;
        if (n_txr - b_txr !== 1) begin
            nfail++;
            $display("FAIL basic_tx_ready_cycles: got %0d required 1", n_txr - b_txr);
        end
        nchk++;
        if (n_udf - b_udf !== 0) begin
            nfail++;
            $display("FAIL basic_udf: got %0d required 0", n_udf - b_udf);
        end
    endtask

    task automatic test_modes();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                load_tx(1, 32'h1234, 32'h0);
                mo[0] = 32'hBEEF;
                snap();
                spi_frame(c[0], p[0], 1'b1, 2'd1, 1, -1, 1'b0, 1'b0);
                nchk++;
                if (rx_data_o !== 32'h0000BEEF) begin
                    nfail++;
                    $display("FAIL mode%0d%0d_rx_data: got %h required 0000beef", c, p, rx_data_o);
                end
                nchk++;
                if (mi[0] !== 32'h1234) begin
                    nfail++;
                    $display("FAIL mode%0d%0d_miso: got %h required 00001234", c, p, mi[0]);
                end
                nchk++;
                if ((n_rxv - b_rxv !== 1) || (n_txr - b_txr !== 1)) begin
                    nfail++;
                    $display("FAIL mode%0d%0d_pulses: got rxv=%0d txr=%0d required 1 1",
                             c, p, n_rxv - b_rxv, n_txr - b_txr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        load_tx(2, 32'hDEADBEEF, 32'h01234567);
        mo[0] = 32'hCAFEF00D;
        mo[1] = 32'h13579BDF;
        snap();
        spi_frame(1'b1, 1'b1, 1'b0, 2'd3, 2, -1, 1'b0, 1'b1);
        nchk++;
        if (mi[0] !== 32'hDEADBEEF) begin
            nfail++;
            $display("FAIL b2b_miso0: got %h required deadbeef", mi[0]);
        end
        nchk++;
        if (mi[1] !== 32'h01234567) begin
            nfail++;
            $display("FAIL b2b_miso1: got %h required 01234567", mi[1]);
        end
        nchk++;
        if (rx_log[b_rxv & 7] !== 32'hCAFEF00D) begin
            nfail++;
            $display("FAIL b2b_rx0: got %h required cafef00d", rx_log[b_rxv & 7]);
        end
        nchk++;
        if (rx_data_o !== 32'h13579BDF) begin
            nfail++;
            $display("FAIL b2b_rx1: got %h required 13579bdf", rx_data_o);
        end
        nchk++;
        if ((n_rxv - b_rxv !== 2) || (n_txr - b_txr !== 2)) begin
            nfail++;
            $display("FAIL b2b_pulses: got rxv=%0d txr=%0d required 2 2", n_rxv - b_rxv, n_txr - b_txr);
        end
    endtask

    task automatic test_underflow();
        load_tx(0, 32'h0, 32'h0);
        mo[0] = 32'h5A;
        snap();
        spi_frame(1'b0, 1'b0, 1'b0, 2'd0, 1, -1, 1'b0, 1'b0);
        nchk++;
        if (mi[0] !== 32'h0) begin
            nfail++;
            $display("FAIL udf_miso: got %h required 00000000", mi[0]);
        end
        nchk++;
        if ((n_udf - b_udf !== 1) || (n_txr - b_txr !== 0)) begin
            nfail++;
            $display("FAIL udf_pulses: got udf=%0d txr=%0d required 1 0", n_udf - b_udf, n_txr - b_txr);
        end
        nchk++;
        if (rx_data_o !== 32'h5A) begin
            nfail++;
            $display("FAIL udf_rx_data: got %h required 0000005a", rx_data_o);
        end
    endtask

    task automatic test_overflow();
        rx_ready_i = 1'b0;
        load_tx(1, 32'h11, 32'h0);
        mo[0] = 32'h77;
        snap();
        spi_frame(1'b0, 1'b1, 1'b0, 2'd0, 1, -1, 1'b0, 1'b0);
        rx_ready_i = 1'b1;
        nchk++;
        if ((n_ovf - b_ovf !== 1) || (n_rxv - b_rxv !== 0)) begin
            nfail++;
            $display("FAIL ovf_pulses: got ovf=%0d rxv=%0d required 1 0", n_ovf - b_ovf, n_rxv - b_rxv);
        end
        nchk++;
        if (rx_data_o !== 32'h77) begin
            nfail++;
            $display("FAIL ovf_rx_data: got %h required 00000077", rx_data_o);
        end
        nchk++;
        if (mi[0] !== 32'h11) begin
            nfail++;
            $display("FAIL ovf_miso: got %h required 00000011", mi[0]);
        end
    endtask

    task automatic test_abort();
        // Abort after 5 bits: bit 0 was sampled, so the word is popped.
        load_tx(1, 32'hC3, 32'h0);
        mo[0] = 32'hFF;
        snap();
        spi_frame(1'b0, 1'b0, 1'b0, 2'd0, 1, 5, 1'b0, 1'b0);
        nchk++;
        if ((n_ferr - b_ferr !== 1) || (n_rxv - b_rxv !== 0) || (n_txr - b_txr !== 1)) begin
            nfail++;
            $display("FAIL abort5_pulses: got ferr=%0d rxv=%0d txr=%0d required 1 0 1",
                     n_ferr - b_ferr, n_rxv - b_rxv, n_txr - b_txr);
        end
        load_tx(1, 32'h42, 32'h0);
        mo[0] = 32'h81;
        snap();
        spi_frame(1'b0, 1'b0, 1'b0, 2'd0, 1, -1, 1'b0, 1'b0);
        nchk++;
        if ((rx_data_o !== 32'h81) || (n_rxv - b_rxv !== 1) || (n_ferr - b_ferr !== 0)) begin
            nfail++;
            $display("FAIL abort5_next: got rx=%h rxv=%0d ferr=%0d required 00000081 1 0",
                     rx_data_o, n_rxv - b_rxv, n_ferr - b_ferr);
        end
        nchk++;
        if (mi[0] !== 32'h42) begin
            nfail++;
            $display("FAIL abort5_next_miso: got %h required 00000042", mi[0]);
        end
        // cpha=1 abort after only the first drive edge: word peeked, never sampled, never popped.
        load_tx(1, 32'h5E, 32'h0);
        snap();
        spi_frame(1'b0, 1'b1, 1'b0, 2'd0, 1, 0, 1'b1, 1'b0);
        nchk++;
        if ((n_txr - b_txr !== 0) || (n_ferr - b_ferr !== 0)) begin
            nfail++;
            $display("FAIL abort0_pulses: got txr=%0d ferr=%0d required 0 0", n_txr - b_txr, n_ferr - b_ferr);
        end
        mo[0] = 32'h81;
        snap();
        spi_frame(1'b0, 1'b1, 1'b0, 2'd0, 1, -1, 1'b0, 1'b0);
        nchk++;
        if ((mi[0] !== 32'h5E) || (n_txr - b_txr !== 1) || (rx_data_o !== 32'h81)) begin
            nfail++;
            $display("FAIL abort0_next: got miso=%h txr=%0d rx=%h required 0000005e 1 00000081",
                     mi[0], n_txr - b_txr, rx_data_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        load_tx(1, 32'h99, 32'h0);
        cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dsize_i = 2'd0;
        spi_sck_i = 1'b0;
        wait_clks(6);
        spi_nss_i  = 1'b0;
        spi_mosi_i = 1'b1;
        wait_clks(8);
        spi_sck_i = 1'b1; wait_clks(5);
        spi_sck_i = 1'b0; wait_clks(5);
        spi_sck_i = 1'b1; wait_clks(2);
        nchk++;
        if (busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL rstmid_busy_before: got %b required 1", busy_o);
        end
        rst_n_i = 1'b0;
        #1;
        nchk++;
        if ({spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o, tx_udf_o, rx_ovf_o, frm_err_o} !== 8'h00
            || rx_data_o !== 32'h0) begin
            nfail++;
            $display("FAIL rstmid_outputs: got %b rx=%h required 00000000 00000000",
                     {spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o, tx_udf_o, rx_ovf_o, frm_err_o},
                     rx_data_o);
        end
        spi_nss_i = 1'b1;
        spi_sck_i = 1'b0;
        wait_clks(5);
        rst_n_i = 1'b1;
        wait_clks(8);
        nchk++;
        if (busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_busy_after: got %b required 0", busy_o);
        end
        load_tx(1, 32'h42, 32'h0);
        mo[0] = 32'h81;
        snap();
        spi_frame(1'b0, 1'b0, 1'b0, 2'd0, 1, -1, 1'b0, 1'b0);
        nchk++;
        if ((rx_data_o !== 32'h81) || (mi[0] !== 32'h42) || (n_rxv - b_rxv !== 1)) begin
            nfail++;
            $display("FAIL rstmid_next: got rx=%h miso=%h rxv=%0d required 00000081 00000042 1",
                     rx_data_o, mi[0], n_rxv - b_rxv);
        end
    endtask

    initial begin
        rst_n_i    = 1'b0;
        en_i       = 1'b1;
        cpol_i     = 1'b0;
        cpha_i     = 1'b0;
        lsb_i      = 1'b0;
        dsize_i    = 2'd0;
        rx_ready_i = 1'b1;
        spi_sck_i  = 1'b0;
        spi_nss_i  = 1'b1;
        spi_mosi_i = 1'b0;
        mo[0] = '0;
        mo[1] = '0;
        txq[0] = '0; txq[1] = '0; txq[2] = '0; txq[3] = '0;

        test_reset();
        test_basic();
        test_modes();
        test_back_to_back();
        test_underflow();
        test_overflow();
        test_abort();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
